// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared state type, clamp limits and default widths for the SSP clock generator
package ssp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ssp_state_e;

  localparam int CPSDVSR_MIN    = 2;
  localparam int DSS_MIN        = 3;
  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_SCR_W      = 8;
  localparam int DEF_DSS_W      = 4;

endpackage

// File: rtl/ssp_rate_div.sv
// rtl/ssp_rate_div.sv - prescale counter cascaded with SCR counter, one-cycle tick every half*(scr+1) cycles
module ssp_rate_div
  import ssp_pkg::*;
#(
  parameter int HALF_W = DEF_PRESCALE_W - 1,
  parameter int SCR_W  = DEF_SCR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  input  logic [SCR_W-1:0]  scr,
  output logic              tick
);

  logic [HALF_W-1:0] pre_q, pre_d;
  logic [SCR_W-1:0]  scr_cnt_q, scr_cnt_d;
  logic              pre_wrap;
  logic              scr_wrap;

  // >= keeps the counters bounded when live divisors shrink mid-count
  always_comb begin
    pre_wrap  = (pre_q >= (half - HALF_W'(1)));
    scr_wrap  = (scr_cnt_q >= scr);
    tick      = pre_wrap && scr_wrap && !clr;
    pre_d     = pre_q + HALF_W'(1);
    scr_cnt_d = scr_cnt_q;
    if (clr) begin
      pre_d     = '0;
      scr_cnt_d = '0;
    end else if (pre_wrap) begin
      pre_d     = '0;
      scr_cnt_d = scr_wrap ? '0 : scr_cnt_q + SCR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      scr_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      scr_cnt_q <= scr_cnt_d;
    end
  end

endmodule

// File: rtl/ssp_clkgen.sv
// rtl/ssp_clkgen.sv - SSP master serial clock, launch/sample strobes and frame timing
// Optional free-running clock output enabled by defining SSP_CLKGEN_FREERUN_EN.
module ssp_clkgen
  import ssp_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int SCR_W      = DEF_SCR_W,
  parameter int DSS_W      = DEF_DSS_W
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  EN,
  input  logic [PRESCALE_W-1:0] CPSDVSR,
  input  logic [SCR_W-1:0]      SCR,
  input  logic [DSS_W-1:0]      DSS,
  input  logic                  SPO,
  input  logic                  SPH,
  input  logic                  START,
`ifdef SSP_CLKGEN_FREERUN_EN
  input  logic                  FREERUN,
`endif
  output logic                  SSPCLKOUT,
  output logic                  BUSY,
  output logic                  LAUNCH_STB,
  output logic                  SAMPLE_STB,
  output logic                  DONE
);

  localparam int HALF_W = PRESCALE_W - 1;
  localparam int EW     = DSS_W + 2;

  ssp_state_e        state_q, state_d;
  logic [HALF_W-1:0] half_q, half_d, half_live, div_half;
  logic [SCR_W-1:0]  scr_q, scr_d, div_scr;
  logic [DSS_W-1:0]  dss_q, dss_d, dss_live;
  logic              sph_q, sph_d;
  logic [EW-1:0]     edge_q, edge_d, edge_nxt, edge_last;
  logic              clk_q, clk_d;
  logic              launch_q, launch_d, sample_q, sample_d, done_q, done_d;
  logic              freerun, tick, div_clr;

`ifdef SSP_CLKGEN_FREERUN_EN
  assign freerun = EN && FREERUN && (state_q == IDLE);
`else
  assign freerun = 1'b0;
`endif

  assign half_live = (CPSDVSR < PRESCALE_W'(CPSDVSR_MIN)) ? HALF_W'(CPSDVSR_MIN / 2)
                                                          : CPSDVSR[PRESCALE_W-1:1];
  assign dss_live  = (DSS < DSS_W'(DSS_MIN)) ? DSS_W'(DSS_MIN) : DSS;
  assign div_half  = freerun ? half_live : half_q;
  assign div_scr   = freerun ? SCR : scr_q;
  assign div_clr   = !EN || !((state_q == RUN) || freerun);
  assign edge_nxt  = edge_q + EW'(1);
  assign edge_last = {({1'b0, dss_q} + (DSS_W + 1)'(1)), 1'b0};

  ssp_rate_div #(
    .HALF_W (HALF_W),
    .SCR_W  (SCR_W)
  ) u_rate_div (
    .clk   (PCLK),
    .rst_n (CLEAR_B),
    .clr   (div_clr),
    .half  (div_half),
    .scr   (div_scr),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    scr_d    = scr_q;
    dss_d    = dss_q;
    sph_d    = sph_q;
    edge_d   = edge_q;
    clk_d    = clk_q;
    launch_d = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    if (!EN) begin
      state_d = IDLE;
      edge_d  = '0;
      clk_d   = SPO;
    end else if (state_q == IDLE) begin
      edge_d = '0;
      clk_d  = SPO;
      if (freerun) begin
        clk_d = tick ? ~clk_q : clk_q;
      end else if (START) begin
        state_d  = RUN;
        half_d   = half_live;
        scr_d    = SCR;
        dss_d    = dss_live;
        sph_d    = SPH;
        launch_d = ~SPH;
      end
    end else if (tick) begin
      clk_d  = ~clk_q;
      edge_d = edge_nxt;
      // odd edge numbers are leading edges
      if (edge_nxt[0]) begin
        launch_d = sph_q;
        sample_d = ~sph_q;
      end else begin
        sample_d = sph_q;
        launch_d = ~sph_q && (edge_nxt != edge_last);
      end
      if (edge_nxt == edge_last) begin
        done_d  = 1'b1;
        state_d = IDLE;
        edge_d  = '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q  <= IDLE;
      half_q   <= '0;
      scr_q    <= '0;
      dss_q    <= '0;
      sph_q    <= 1'b0;
      edge_q   <= '0;
      clk_q    <= 1'b0;
      launch_q <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      scr_q    <= scr_d;
      dss_q    <= dss_d;
      sph_q    <= sph_d;
      edge_q   <= edge_d;
      clk_q    <= clk_d;
      launch_q <= launch_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign SSPCLKOUT  = clk_q;
  assign BUSY       = (state_q == RUN);
  assign LAUNCH_STB = launch_q;
  assign SAMPLE_STB = sample_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_ssp_clkgen.sv
// tb/tb_ssp_clkgen.sv - self-checking bench for ssp_clkgen against a cycle-indexed reference model
module tb_ssp_clkgen;

  logic       PCLK;
  logic       CLEAR_B;
  logic       EN;
  logic [7:0] CPSDVSR;
  logic [7:0] SCR;
  logic [3:0] DSS;
  logic       SPO;
  logic       SPH;
  logic       START;
  logic       FREERUN;
  logic       SSPCLKOUT, BUSY, LAUNCH_STB, SAMPLE_STB, DONE;
  logic [4:0] obs;
  int         n_checks;
  int         n_fail;

  assign obs = {SSPCLKOUT, BUSY, LAUNCH_STB, SAMPLE_STB, DONE};

  ssp_clkgen dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .EN         (EN),
    .CPSDVSR    (CPSDVSR),
    .SCR        (SCR),
    .DSS        (DSS),
    .SPO        (SPO),
    .SPH        (SPH),
    .START      (START),
`ifdef SSP_CLKGEN_FREERUN_EN
    .FREERUN    (FREERUN),
`endif
    .SSPCLKOUT  (SSPCLKOUT),
    .BUSY       (BUSY),
    .LAUNCH_STB (LAUNCH_STB),
    .SAMPLE_STB (SAMPLE_STB),
    .DONE       (DONE)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Expected {clk, busy, launch, sample, done} t cycles after the edge that took START.
  function automatic logic [4:0] ref_out(input int t, input int h, input int n,
                                         input logic spo, input logic sph);
    int   k;
    int   last;
    logic on_edge, lead, trail, la, sa;
    k       = t / h;
    last    = 2 * n * h;
    if (t > last) return {spo, 4'b0000};
    on_edge = (t > 0) && (t % h == 0);
    lead    = on_edge && k[0];
    trail   = on_edge && !k[0];
    sa      = sph ? trail : lead;
    la      = sph ? lead : ((t == 0) || (trail && t < last));
    return {spo ^ k[0], t < last, la, sa, t == last};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic run_frame(input int cps, input int scr, input int dss, input logic spo,
                           input logic sph, input bit perturb, input int abort_at);
    int h, n, last;
    h    = ((cps < 2 ? 2 : cps) / 2) * (scr + 1);
    n    = (dss < 3 ? 3 : dss) + 1;
    last = 2 * n * h;
    @(negedge PCLK);
    CPSDVSR = 8'(cps);
    SCR     = 8'(scr);
    DSS     = 4'(dss);
    SPO     = spo;
    SPH     = sph;
    START   = 1'b1;
    for (int t = 0; t <= last + 1; t++) begin
      @(negedge PCLK);
      if (abort_at >= 0 && t > abort_at)
        check($sformatf("abort h=%0d t=%0d", h, t), obs, {spo, 4'b0000});
      else
        check($sformatf("frame h=%0d n=%0d sph=%0b spo=%0b t=%0d", h, n, sph, spo, t),
              obs, ref_out(t, h, n, spo, sph));
      EN = 1'b1;
      if (perturb && t < last - 2) begin
        CPSDVSR = 8'($urandom);
        SCR     = 8'($urandom);
        DSS     = 4'($urandom);
        SPO     = 1'($urandom);
        SPH     = 1'($urandom);
        START   = 1'($urandom);
      end else begin
        CPSDVSR = 8'(cps);
        SCR     = 8'(scr);
        DSS     = 4'(dss);
        SPO     = spo;
        SPH     = sph;
        START   = 1'b0;
      end
      if (t == last - 1 && abort_at < 0) START = 1'b1;
      if (t == abort_at) EN = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    CLEAR_B  = 1'b0;
    EN       = 1'b1;
    CPSDVSR  = 8'd2;
    SCR      = 8'd0;
    DSS      = 4'd7;
    SPO      = 1'b0;
    SPH      = 1'b0;
    START    = 1'b0;
    FREERUN  = 1'b0;

    repeat (3) @(negedge PCLK);
    check("reset state", obs, 5'b00000);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
    check("idle after reset", obs, 5'b00000);

    run_frame(2, 0, 7, 1'b0, 1'b0, 1'b0, -1);
    run_frame(4, 2, 3, 1'b1, 1'b1, 1'b0, -1);
    run_frame(1, 0, 3, 1'b0, 1'b1, 1'b0, -1);
    run_frame(5, 0, 0, 1'b1, 1'b0, 1'b0, -1);
    run_frame(2, 0, 7, 1'b1, 1'b0, 1'b0, 4);

    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 6),
                1'($urandom), 1'($urandom), 1'b1, -1);

    // asynchronous clear in the middle of an H=1 frame
    @(negedge PCLK);
    CPSDVSR = 8'd2;
    SCR     = 8'd0;
    DSS     = 4'd3;
    SPO     = 1'b0;
    SPH     = 1'b0;
    START   = 1'b1;
    @(negedge PCLK);
    START = 1'b0;
    repeat (3) @(negedge PCLK);
    check("pre-clear frame", obs, ref_out(3, 1, 4, 1'b0, 1'b0));
    CLEAR_B = 1'b0;
    SPO     = 1'b1;
    #1;
    check("async clear", obs, 5'b00000);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(posedge PCLK);
    #1;
    check("release spo=1", obs, 5'b10000);

`ifdef SSP_CLKGEN_FREERUN_EN
    @(negedge PCLK);
    CPSDVSR = 8'd2;
    SCR     = 8'd1;
    SPO     = 1'b0;
    FREERUN = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge PCLK);
      check($sformatf("freerun t=%0d", t), obs, {1'((t / 2) % 2), 4'b0000});
      START = (t == 3);
    end
    FREERUN = 1'b0;
    @(negedge PCLK);
    check("freerun drop", obs, 5'b00000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
